// File: rtl/jtvigil_snd_latch.sv
// Sound-CPU-side endpoint of the main-to-sound command path.
// Captures main CPU latch writes and raises the sound Z80 INT with an RST
// vector merged from latch-pending and the YM2151 IRQ. Decodes the sound CPU
// I/O ports and generates the periodic sample-playback NMI.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   cen            sound CPU clock enable (paces the NMI counter)
//   main_latch_wr  main CPU latch write strobe (level, may span several clk)
//   main_dout      main CPU data bus
//   snd_a          sound CPU address A[7:0]
//   io_rd, io_wr   sound CPU I/O read / write (active-high)
//   int_ack        interrupt acknowledge cycle (m1 & iorq)
//   snd_dout       sound CPU data out
//   ym_irq_n       YM2151 interrupt, active-low
//   io_dout        data to sound CPU for decoded reads / int_ack, FF otherwise
//   io_hit         io_dout must be muxed onto the sound CPU bus
//   int_n, nmi_n   sound CPU interrupts, active-low
//   sample_addr    sample ROM address
//   sample_data    sample ROM byte at sample_addr
//   dac            DAC value
module jtvigil_snd_latch #(
  parameter int unsigned NMI_DIV = 508,
  parameter int unsigned NMI_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        main_latch_wr,
  input  logic [7:0]  main_dout,
  input  logic [7:0]  snd_a,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic        int_ack,
  input  logic [7:0]  snd_dout,
  input  logic        ym_irq_n,
  output logic [7:0]  io_dout,
  output logic        io_hit,
  output logic        int_n,
  output logic        nmi_n,
  output logic [15:0] sample_addr,
  input  logic [7:0]  sample_data,
  output logic [7:0]  dac
);

  localparam int unsigned CW = $clog2(NMI_DIV);

  logic [7:0]    latch;
  logic          pending;
  logic          latch_wr_l;
  logic          io_wr_l;
  logic          io_rd_l;
  logic          rd4_l;
  logic [CW-1:0] nmi_cnt;

  logic          port_sel;
  logic [2:0]    port;
  logic          latch_rise;
  logic          wr_rise;
  logic          rd_latch;
  logic          rd_sample;
  logic          rd4_fall;
  logic [7:0]    vector;

  // A[6:3] are don't-care in the port decode
  logic unused_addr;
  assign unused_addr = ^snd_a[6:3];

  // Port decode and edge detection
  always_comb begin
    port_sel   = snd_a[7];
    port       = snd_a[2:0];
    latch_rise = main_latch_wr & ~latch_wr_l;
    wr_rise    = io_wr & ~io_wr_l & port_sel;
    rd_latch   = io_rd & port_sel & (port == 3'd0);
    rd_sample  = io_rd & port_sel & (port == 3'd4);
    rd4_fall   = rd4_l & io_rd_l & ~io_rd;
  end

  // RST vector: bit5 low for pending latch, bit4 low for YM IRQ
  always_comb begin
    vector = {2'b11, ~pending, ym_irq_n, 4'hF};
    int_n  = (vector == 8'hFF);
  end

  // Read data mux towards the sound CPU
  always_comb begin
    io_dout = 8'hFF;
    io_hit  = 1'b0;
    if (int_ack) begin
      io_dout = vector;
      io_hit  = 1'b1;
    end else if (rd_latch) begin
      io_dout = latch;
      io_hit  = 1'b1;
    end else if (rd_sample) begin
      io_dout = sample_data;
      io_hit  = 1'b1;
    end
  end

  // Edge detector history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_wr_l <= 1'b0;
      io_wr_l    <= 1'b0;
      io_rd_l    <= 1'b0;
      rd4_l      <= 1'b0;
    end else begin
      latch_wr_l <= main_latch_wr;
      io_wr_l    <= io_wr;
      io_rd_l    <= io_rd;
      rd4_l      <= rd_sample;
    end
  end

  // Command latch; a new capture beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch   <= 8'h00;
      pending <= 1'b0;
    end else if (latch_rise) begin
      latch   <= main_dout;
      pending <= 1'b1;
    end else if (wr_rise && port == 3'd3) begin
      pending <= 1'b0;
    end
  end

  // Sample address: CPU-loaded bytes, post-increment after each sample read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_addr <= 16'h0000;
    end else if (wr_rise && port == 3'd0) begin
      sample_addr[7:0] <= snd_dout;
    end else if (wr_rise && port == 3'd1) begin
      sample_addr[15:8] <= snd_dout;
    end else if (rd4_fall) begin
      sample_addr <= sample_addr + 16'd1;
    end
  end

  // DAC output register, mid-scale at reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac <= 8'h80;
    end else if (wr_rise && port == 3'd2) begin
      dac <= snd_dout;
    end
  end

  // NMI: nmi_n reflects the count value at each cen, so the first low
  // phase begins on the first cen after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_cnt <= '0;
      nmi_n   <= 1'b1;
    end else if (cen) begin
      nmi_n   <= (nmi_cnt >= CW'(NMI_LEN));
      nmi_cnt <= (nmi_cnt == CW'(NMI_DIV - 1)) ? '0 : nmi_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_jtvigil_snd_latch.sv
module tb_jtvigil_snd_latch;

  logic        clk;
  logic        rst;
  logic        cen;
  logic        main_latch_wr;
  logic [7:0]  main_dout;
  logic [7:0]  snd_a;
  logic        io_rd;
  logic        io_wr;
  logic        int_ack;
  logic [7:0]  snd_dout;
  logic        ym_irq_n;
  logic [7:0]  io_dout;
  logic        io_hit;
  logic        int_n;
  logic        nmi_n;
  logic [15:0] sample_addr;
  logic [7:0]  sample_data;
  logic [7:0]  dac;

  int total = 0;
  int bad   = 0;

  jtvigil_snd_latch #(.NMI_DIV(508), .NMI_LEN(32)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .main_latch_wr(main_latch_wr), .main_dout(main_dout),
    .snd_a(snd_a), .io_rd(io_rd), .io_wr(io_wr), .int_ack(int_ack),
    .snd_dout(snd_dout), .ym_irq_n(ym_irq_n),
    .io_dout(io_dout), .io_hit(io_hit), .int_n(int_n), .nmi_n(nmi_n),
    .sample_addr(sample_addr), .sample_data(sample_data), .dac(dac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample ROM contents
  function automatic logic [7:0] rom(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[15:8];
    return a[7:0] + 8'(hi * 8'd3);
  endfunction

  assign sample_data = rom(sample_addr);

  typedef struct {
    string      name;
    logic [7:0] a;
    logic       hit;
    logic [7:0] dout;
  } rd_vec_t;

  rd_vec_t tbl[11];

  // Reference model state
  logic [7:0]  m_latch;
  logic        m_pend;
  logic [15:0] m_addr;
  logic [7:0]  m_dac;

  function automatic logic [7:0] m_vec(input logic pend, input logic ym_n);
    logic [7:0] v;
    v = 8'hFF;
    if (!ym_n) v = v & 8'hEF;
    if (pend)  v = v & 8'hDF;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic main_write(input logic [7:0] v, input int n, input logic [7:0] v_after);
    main_dout = v;
    main_latch_wr = 1'b1;
    tick();
    main_dout = v_after;
    repeat (n - 1) tick();
    main_latch_wr = 1'b0;
    tick();
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    snd_a = a;
    snd_dout = d;
    io_wr = 1'b1;
    tick();
    io_wr = 1'b0;
    tick();
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic h);
    snd_a = a;
    io_rd = 1'b1;
    #1;
    d = io_dout;
    h = io_hit;
    tick();
    io_rd = 1'b0;
    tick();
  endtask

  task automatic ack(output logic [7:0] d, output logic h);
    int_ack = 1'b1;
    #1;
    d = io_dout;
    h = io_hit;
    tick();
    int_ack = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] d;
    logic       h;
    logic [7:0] v;
    logic [7:0] a;
    logic [2:0] sel;

    rst = 1'b1; cen = 1'b0; main_latch_wr = 1'b0; main_dout = 8'h00;
    snd_a = 8'h00; io_rd = 1'b0; io_wr = 1'b0; int_ack = 1'b0;
    snd_dout = 8'h00; ym_irq_n = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_nmi_n", 16'(nmi_n), 16'h1);
    chk("rst_int_n", 16'(int_n), 16'h1);
    chk("rst_dac", 16'(dac), 16'h80);
    chk("rst_addr", sample_addr, 16'h0000);
    chk("rst_io_dout", 16'(io_dout), 16'hFF);
    chk("rst_io_hit", 16'(io_hit), 16'h0);
    rst = 1'b0;
    tick();

    // Test 1: 4-clk strobe, data changes after first clk, one capture
    main_write(8'h3C, 4, 8'h11);
    chk("t1_int_n", 16'(int_n), 16'h0);
    ack(d, h);
    chk("t1_ack_vec", 16'(d), 16'hDF);
    chk("t1_ack_hit", 16'(h), 16'h1);
    io_read(8'h80, d, h);
    chk("t1_latch", 16'(d), 16'h3C);
    chk("t1_pend_kept", 16'(int_n), 16'h0);

    // Test 2: merged vector, clear via port 3
    ym_irq_n = 1'b0;
    ack(d, h);
    chk("t2_ack_both", 16'(d), 16'hCF);
    io_write(8'h83, 8'hAA);
    ack(d, h);
    chk("t2_ack_ym", 16'(d), 16'hEF);
    ym_irq_n = 1'b1;
    #1;
    chk("t2_int_n_idle", 16'(int_n), 16'h1);

    // Test 3: sample address wrap
    io_write(8'h80, 8'hFE);
    io_write(8'h81, 8'hFF);
    chk("t3_addr_load", sample_addr, 16'hFFFE);
    io_read(8'h84, d, h);
    chk("t3_rd0", 16'(d), 16'(rom(16'hFFFE)));
    chk("t3_rd0_hit", 16'(h), 16'h1);
    io_read(8'h84, d, h);
    chk("t3_rd1", 16'(d), 16'(rom(16'hFFFF)));
    io_read(8'h84, d, h);
    chk("t3_rd2", 16'(d), 16'(rom(16'h0000)));
    chk("t3_addr_end", sample_addr, 16'h0001);

    // Test 4: capture beats a same-cycle clear; overwrite while pending
    main_latch_wr = 1'b1; main_dout = 8'h99;
    snd_a = 8'h83; io_wr = 1'b1;
    tick();
    main_latch_wr = 1'b0; io_wr = 1'b0;
    tick();
    chk("t4_cap_wins", 16'(int_n), 16'h0);
    main_write(8'h5A, 2, 8'h00);
    io_read(8'h80, d, h);
    chk("t4_overwrite", 16'(d), 16'h5A);
    chk("t4_still_pend", 16'(int_n), 16'h0);

    // Read decode table, latch holds 5A
    tbl[0]  = '{"rd80", 8'h80, 1'b1, 8'h5A};
    tbl[1]  = '{"rdC0", 8'hC0, 1'b1, 8'h5A};
    tbl[2]  = '{"rdF8", 8'hF8, 1'b1, 8'h5A};
    tbl[3]  = '{"rd00", 8'h00, 1'b0, 8'hFF};
    tbl[4]  = '{"rd04", 8'h04, 1'b0, 8'hFF};
    tbl[5]  = '{"rd81", 8'h81, 1'b0, 8'hFF};
    tbl[6]  = '{"rd82", 8'h82, 1'b0, 8'hFF};
    tbl[7]  = '{"rd83", 8'h83, 1'b0, 8'hFF};
    tbl[8]  = '{"rd85", 8'h85, 1'b0, 8'hFF};
    tbl[9]  = '{"rd87", 8'h87, 1'b0, 8'hFF};
    tbl[10] = '{"rd7C", 8'h7C, 1'b0, 8'hFF};
    for (int i = 0; i < 11; i++) begin
      io_read(tbl[i].a, d, h);
      chk({tbl[i].name, "_dout"}, 16'(d), 16'(tbl[i].dout));
      chk({tbl[i].name, "_hit"}, 16'(h), 16'(tbl[i].hit));
    end
    chk("tbl_addr_untouched", sample_addr, 16'h0001);

    // Test 5: NMI timing with cen every clk, plus DAC write
    do_reset();
    chk("t5_nmi_idle", 16'(nmi_n), 16'h1);
    cen = 1'b1;
    for (int k = 1; k <= 1016; k++) begin
      tick();
      chk($sformatf("t5_nmi_%0d", k), 16'(nmi_n), (((k - 1) % 508) < 32) ? 16'h0 : 16'h1);
    end
    io_write(8'h82, 8'h40);
    chk("t5_dac", 16'(dac), 16'h40);

    // Test 6: async reset during NMI pulse with latch pending
    cen = 1'b0;
    do_reset();
    cen = 1'b1;
    repeat (10) tick();
    main_write(8'h77, 3, 8'h00);
    io_write(8'h80, 8'h12);
    io_write(8'h82, 8'h33);
    chk("t6_pre_nmi", 16'(nmi_n), 16'h0);
    chk("t6_pre_int", 16'(int_n), 16'h0);
    chk("t6_pre_addr", sample_addr, 16'h0012);
    #3 rst = 1'b1;
    #1;
    chk("t6_nmi_n", 16'(nmi_n), 16'h1);
    chk("t6_int_n", 16'(int_n), 16'h1);
    chk("t6_dac", 16'(dac), 16'h80);
    chk("t6_addr", sample_addr, 16'h0000);
    tick();
    rst = 1'b0;
    cen = 1'b0;
    tick();

    // Randomized transactions against the reference model
    do_reset();
    m_latch = 8'h00; m_pend = 1'b0; m_addr = 16'h0000; m_dac = 8'h80;
    for (int n = 0; n < 300; n++) begin
      ym_irq_n = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin
          v = 8'($urandom);
          main_write(v, int'($urandom_range(1, 4)), 8'($urandom));
          m_latch = v;
          m_pend = 1'b1;
        end
        1: begin
          sel = 3'($urandom_range(0, 3));
          a = {1'b1, 4'($urandom), sel};
          v = 8'($urandom);
          io_write(a, v);
          case (sel)
            3'd0: m_addr = {m_addr[15:8], v};
            3'd1: m_addr = {v, m_addr[7:0]};
            3'd2: m_dac = v;
            default: m_pend = 1'b0;
          endcase
        end
        2: begin
          a = {1'b1, 4'($urandom), 3'd0};
          io_read(a, d, h);
          chk("r_latch", 16'(d), 16'(m_latch));
          chk("r_latch_hit", 16'(h), 16'h1);
        end
        3: begin
          a = {1'b1, 4'($urandom), 3'd4};
          io_read(a, d, h);
          chk("r_sample", 16'(d), 16'(rom(m_addr)));
          m_addr = m_addr + 16'd1;
        end
        4: begin
          ack(d, h);
          chk("r_ack", 16'(d), 16'(m_vec(m_pend, ym_irq_n)));
          chk("r_ack_hit", 16'(h), 16'h1);
        end
        default: begin
          a = {1'b0, 7'($urandom)};
          io_write(a, 8'($urandom));
          io_read(a, d, h);
          chk("r_undec_hit", 16'(h), 16'h0);
        end
      endcase
      chk("r_addr", sample_addr, m_addr);
      chk("r_dac", 16'(dac), 16'(m_dac));
      chk("r_int_n", 16'(int_n), 16'(m_vec(m_pend, ym_irq_n) == 8'hFF));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
